// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter
// Round-robin arbiter that shares one external 8-bit add/sub datapath
// between NREQ requesters. Each accepted request gets exactly one tagged
// response. The response side uses a valid/ready handshake for backpressure,
// and a saturating counter tracks how many completed responses overflowed.

module addsub_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]     req_op,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          dp_a,
    output logic [7:0]          dp_b,
    output logic                dp_opcode,
    input  logic [7:0]          dp_sum,
    input  logic                dp_ovf,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [7:0]          rsp_sum,
    output logic                rsp_ovf,
    output logic [7:0]          ovf_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [ID_W:0]   cand;

    // Search for the winner starting just after the last grant, wrapping
    // modulo NREQ, so a held request is served within NREQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Accept pulse is combinational so the winner sees it in the same cycle
    // as its request; it can only ever fire while the block is idle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Main sequencer: IDLE latches the winner's operands straight into the
    // datapath drive registers, EXEC captures the datapath result, and RESP
    // holds the response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= ID_W'(NREQ - 1);
            dp_a      <= 8'h00;
            dp_b      <= 8'h00;
            dp_opcode <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= 8'h00;
            rsp_ovf   <= 1'b0;
            ovf_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        dp_a      <= req_a[8*int'(grant_idx) +: 8];
                        dp_b      <= req_b[8*int'(grant_idx) +: 8];
                        dp_opcode <= req_op[grant_idx];
                        rsp_id    <= grant_idx;
                        rr_ptr    <= grant_idx;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= dp_sum;
                    rsp_ovf   <= dp_ovf;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_ovf && ovf_count != 8'hFF) begin
                            ovf_count <= ovf_count + 8'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter
// Directed bench for addsub_rr_arbiter. It provides a behavioural add/sub
// datapath and checks the arbiter against hand-computed expected values.

module tb_addsub_rr_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_op;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          dp_a;
    logic [7:0]          dp_b;
    logic                dp_opcode;
    logic [7:0]          dp_sum;
    logic                dp_ovf;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [7:0]          rsp_sum;
    logic                rsp_ovf;
    logic [7:0]          ovf_count;
    logic                busy;

    int checks;
    int fails;
    int exp_cnt;

    addsub_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_opcode (dp_opcode),
        .dp_sum    (dp_sum),
        .dp_ovf    (dp_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .ovf_count (ovf_count),
        .busy      (busy)
    );

    // Behavioural stand-in for the shared external add/sub datapath.
    assign dp_sum = dp_opcode ? (dp_a + ~dp_b + 8'd1) : (dp_a + dp_b);
    assign dp_ovf = dp_opcode ? ((dp_a[7] != dp_b[7]) && (dp_sum[7] != dp_a[7]))
                              : ((dp_a[7] == dp_b[7]) && (dp_sum[7] != dp_a[7]));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},      32'(busy),      32'h0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
        checkOutput({tag, "_rsp_sum"},   32'(rsp_sum),   32'h0);
        checkOutput({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'h0);
        checkOutput({tag, "_dp_a"},      32'(dp_a),      32'h0);
        checkOutput({tag, "_dp_b"},      32'(dp_b),      32'h0);
        checkOutput({tag, "_dp_opcode"}, 32'(dp_opcode), 32'h0);
        checkOutput({tag, "_ovf_count"}, 32'(ovf_count), 32'h0);
    endtask

    // One isolated request from requester idx, run through to the handshake.
    // Called one step after a rising edge with the arbiter idle.
    task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                                 input logic op, input logic [7:0] exp_sum,
                                 input logic exp_ovf);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_op[idx]       = op;
        req_valid         = '0;
        req_valid[idx]    = 1'b1;
        rsp_ready         = 1'b1;
        #1;
        checkOutput("grant", 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid = '0;
        checkOutput("exec_busy",   32'(busy),      32'h1);
        checkOutput("exec_dp_a",   32'(dp_a),      32'(a));
        checkOutput("exec_dp_b",   32'(dp_b),      32'(b));
        checkOutput("exec_dp_op",  32'(dp_opcode), 32'(op));
        checkOutput("exec_rvalid", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("resp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("resp_id",    32'(rsp_id),    32'(idx));
        checkOutput("resp_sum",   32'(rsp_sum),   32'(exp_sum));
        checkOutput("resp_ovf",   32'(rsp_ovf),   32'(exp_ovf));
        checkOutput("resp_ready", 32'(req_ready), 32'h0);
        tick();
        if (exp_ovf && exp_cnt < 255) begin
            exp_cnt++;
        end
        checkOutput("done_valid", 32'(rsp_valid), 32'h0);
        checkOutput("done_busy",  32'(busy),      32'h0);
        checkOutput("ovf_count",  32'(ovf_count), 32'(exp_cnt));
    endtask

    // Directed test sequence.
    initial begin
        checks    = 0;
        fails     = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        #2;
        checkResetValues("reset");
        #10;
        rst_n = 1'b1;
        tick();

        $display("[TB] single request and subtract cases");
        applyStimulus(0, 8'h64, 8'h32, 1'b0, 8'h96, 1'b1);
        applyStimulus(2, 8'h05, 8'h03, 1'b1, 8'h02, 1'b0);
        applyStimulus(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);

        $display("[TB] round-robin with all requesters valid");
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = 8'((i + 1) * 16);
            req_b[i*8 +: 8] = 8'(i + 1);
            req_op[i]       = 1'b0;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            checkOutput("rr_exec_ready", 32'(req_ready), 32'h0);
            tick();
            checkOutput("rr_valid", 32'(rsp_valid), 32'h1);
            checkOutput("rr_id",    32'(rsp_id),    32'(k % 4));
            checkOutput("rr_sum",   32'(rsp_sum),   32'(((k % 4) + 1) * 17));
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();

        $display("[TB] backpressure");
        req_a[1*8 +: 8] = 8'h7F;
        req_b[1*8 +: 8] = 8'hFF;
        req_op[1]       = 1'b1;
        req_valid       = 4'b0010;
        rsp_ready       = 1'b1;
        #1;
        checkOutput("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        req_a[3*8 +: 8] = 8'h10;
        req_b[3*8 +: 8] = 8'h20;
        req_op[3]       = 1'b0;
        req_valid       = 4'b1000;
        rsp_ready       = 1'b0;
        #1;
        checkOutput("bp_exec_ready", 32'(req_ready), 32'h0);
        tick();
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp_sum",   32'(rsp_sum),   32'h80);
            checkOutput("bp_id",    32'(rsp_id),    32'h1);
            checkOutput("bp_ready", 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_count",  32'(ovf_count), 32'h1);
        checkOutput("bp_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        checkOutput("bp3_id",  32'(rsp_id),  32'h3);
        checkOutput("bp3_sum", 32'(rsp_sum), 32'h30);
        checkOutput("bp3_ovf", 32'(rsp_ovf), 32'h0);
        tick();

        $display("[TB] reset during EXEC");
        req_a[2*8 +: 8] = 8'h11;
        req_b[2*8 +: 8] = 8'h22;
        req_op[2]       = 1'b0;
        req_valid       = 4'b0100;
        #1;
        checkOutput("mid_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        checkOutput("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkResetValues("mid_reset");
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("mid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req_a[0 +: 8] = 8'h01;
        req_b[0 +: 8] = 8'h02;
        req_op[0]     = 1'b0;
        req_valid     = '1;
        #1;
        checkOutput("mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        checkOutput("mid_rsp_id",  32'(rsp_id),  32'h0);
        checkOutput("mid_rsp_sum", 32'(rsp_sum), 32'h03);
        tick();
        exp_cnt = 0;

        $display("[TB] overflow counter saturation");
        for (int n = 0; n < 260; n++) begin
            applyStimulus(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
            if (n == 253) begin
                checkOutput("sat_254", 32'(ovf_count), 32'd254);
            end
        end
        checkOutput("sat_hold", 32'(ovf_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
